// File: rtl/mem_pkg.sv
// Shared constants for the memory arbiter slice: default bus widths and port indices.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 15;
  localparam int unsigned MEM_DATA_W = 16;

  // Requester indices into the request/grant vectors
  localparam int unsigned N_PORTS = 2;
  localparam bit          PORT_F  = 1'b0;
  localparam bit          PORT_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with round-robin or fixed (D wins) priority.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   req        : request vector, indexed by PORT_F / PORT_D
//   gnt_c      : one-hot-or-zero grant vector (combinational, zero during reset)
module rr_arb2
  import mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] gnt_c
);

  // 1 = D was granted most recently, so F is preferred on the next contention
  logic last_d;

  // Grant selection
  always_comb begin
    gnt_c = '0;
    if (rst_n) begin
      if (req[PORT_F] && req[PORT_D]) begin
        if (FIXED_PRIO || !last_d) begin
          gnt_c[PORT_D] = 1'b1;
        end else begin
          gnt_c[PORT_F] = 1'b1;
        end
      end else begin
        gnt_c = req;
      end
    end
  end

  // Pointer only moves when something is granted; idle cycles keep it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (|gnt_c) begin
      last_d <= gnt_c[PORT_D];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port (read-only)
// and the load/store port (read/write). One access per cycle, 1-cycle read latency.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   f_req/f_addr/f_gnt/f_rvalid        : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid : load/store requester
//   rdata                              : shared read data (memory output passed through)
//   mem_addr/mem_di/mem_we/mem_re/mem_do : memory interface
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_do
);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] gnt;
  logic               f_rv_q;
  logic               d_rv_q;

  // Pack requests by port index
  always_comb begin
    req         = '0;
    req[PORT_F] = f_req;
    req[PORT_D] = d_req;
  end

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt_c (gnt)
  );

  assign f_gnt = gnt[PORT_F];
  assign d_gnt = gnt[PORT_D];

  // Memory drive; with no grant the fetch address is presented
  assign mem_addr = d_gnt ? d_addr : f_addr;
  assign mem_di   = d_wdata;
  assign mem_we   = d_gnt & d_we;
  assign mem_re   = f_gnt | (d_gnt & ~d_we);
  assign rdata    = mem_do;

  // Response owner tracking, aligned with the memory's registered output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_rv_q <= 1'b0;
      d_rv_q <= 1'b0;
    end else begin
      f_rv_q <= f_gnt;
      d_rv_q <= d_gnt & ~d_we;
    end
  end

  // Reset also masks a response still in flight from the cycle before reset
  assign f_rvalid = f_rv_q & rst_n;
  assign d_rvalid = d_rv_q & rst_n;

endmodule
